prim_generic_flop_ser: RTL and testbench
========================================

# prim_generic_flop_ser

Readout counterpart to the enable-gated capture flop. On an enable pulse it captures a `Width`-bit word into a holding register. It then streams the word out as `Width/ChunkW` beats over a valid/ready interface, so a narrow consumer (debug port, scan-style readout, narrow bus bridge) can read a wide register one chunk at a time. It sits between a wide register source and a narrow stream sink in the same clock domain.

## Interface
- `Width`, default 32: captured word width.
- `ChunkW`, default 8: beat width.
  - Must divide `Width`; elaboration-time assertion.
- `ResetValue`, default 0: holding-register reset value (`Width` bits).
- `MsbFirst`, default 0:
  - 0: beat 0 is bits `[ChunkW-1:0]`.
  - 1: beat 0 is the top chunk.
- Derived: `NumBeats = Width/ChunkW`, `CntW = max(1, $clog2(NumBeats))`.
- `clk_i` in 1: clock. One clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: capture request.
- `d_i` in `Width`: word to capture.
- `q_o` out `Width`: holding register contents.
- `busy_o` out 1: serializer is in SEND.
- `valid_o` out 1: beat valid.
- `ready_i` in 1: sink accepts beat.
- `data_o` out `ChunkW`: beat payload.
- `last_o` out 1: current beat is the final beat of the word.
- `drop_o` out 1: registered one-cycle pulse; a capture request was refused.

## Operation
- States: IDLE, SEND.
  - `busy_o = valid_o = (state == SEND)`.
- IDLE:
  - `en_i=1`: `q_o <= d_i`, `cnt <= 0`, state goes to SEND.
  - `en_i=0`: hold.
- SEND:
  - `data_o` = chunk `cnt` (index mirrored when `MsbFirst`).
  - `last_o = (cnt == NumBeats-1)`.
- Handshake: a beat transfers when `valid_o && ready_i`.
  - Transfer with `last_o=0`: `cnt <= cnt+1`.
  - Transfer with `last_o=1` and `en_i=0`: state goes to IDLE, `cnt <= 0`.
  - Transfer with `last_o=1` and `en_i=1`: back-to-back capture. `q_o <= d_i`, `cnt <= 0`, stay in SEND. No bubble, no drop.
- `en_i=1` in SEND without a last-beat transfer:
  - The request is ignored and `q_o` is unchanged.
  - `drop_o=1` the next cycle.
- While `valid_o && !ready_i`: `data_o`, `last_o` and `q_o` stay stable. `valid_o` never deasserts before the transfer.
- `NumBeats==1`: every beat is last.
  - `cnt` stays 0.
  - `last_o` is 1 whenever `valid_o` is 1.
- `ready_i` in IDLE: ignored.
- `cnt` never exceeds `NumBeats-1`; no wrap-around past the final beat.

## Timing
- Reset values:
  - `q_o = ResetValue`.
  - state IDLE.
  - `cnt = 0`.
  - `busy_o`, `valid_o`, `last_o`, `drop_o` = 0.
  - `data_o` = chunk 0 of `ResetValue`.
- Reset mid-word: the word is abandoned and all reset values apply the next cycle. Reset has priority over `en_i` and `ready_i`.
- Latency:
  - `en_i` at edge n gives `valid_o=1` and beat 0 after edge n.
  - With `ready_i` held high, a word takes `NumBeats` cycles.
  - Back-to-back sustained throughput: one beat per cycle.
- `drop_o`: registered, one cycle after the refused `en_i` edge. One pulse per refused cycle.
- No combinational path from `ready_i` or `en_i` to `valid_o`, `data_o` or `last_o`.

## Structure
- Package `prim_ser_pkg`: `ser_state_e` enum (IDLE, SEND).
- Single module. The holding register and beat counter are implemented inline with synchronous active-high reset.
- No sub-module. Chunk selection is combinational from `q_o` and `cnt`.

## Test plan
- Reset then idle (`Width=32`, `ChunkW=8`, `ResetValue=32'hCAFE_F00D`): required response:
  - `q_o=CAFEF00D`, `valid_o=0`, `data_o=0D`.
- Single capture, `ready_i=1`, `d_i=32'h1122_3344`, LSB-first: required response:
  - beats `44,33,22,11` on 4 consecutive cycles.
  - `last_o` only on `11`.
  - `busy_o` low the following cycle.
- Backpressure: `ready_i` low for 3 cycles on beat 1. Required response:
  - `data_o=33` held stable.
  - `valid_o` stays high.
  - No beat skipped.
- Back-to-back: `en_i=1` with `d_i=AABBCCDD` on the last-beat transfer. Required response:
  - Next beat is `DD` with no idle cycle.
  - `drop_o=0`.
- Refused capture: `en_i` during beat 1 of `11223344`. Required response:
  - `drop_o` pulses 1 cycle.
  - Stream still `44,33,22,11`.
  - `q_o` unchanged.
- Mid-word `rst_i` after beat 2, plus `MsbFirst=1` variant (`d_i=11223344`). Required response:
  - Reset returns to IDLE with `q_o=ResetValue` next cycle.
  - MSB-first stream order is `11,22,33,44`.

Source files
------------

// File: rtl/prim_ser_pkg.sv
// prim_ser_pkg: shared types for the word serializer (state encoding)
package prim_ser_pkg;
   typedef enum logic {IDLE, SEND} ser_state_e;
endpackage

// File: rtl/prim_generic_flop_ser.sv
// prim_generic_flop_ser: capture a wide word on en_i, stream it out as Width/ChunkW valid/ready beats
// Ports: clk_i/rst_i clock and sync active-high reset; en_i/d_i capture request and word;
// q_o holding register; busy_o serializer active; valid_o/ready_i/data_o/last_o beat stream;
// drop_o registered pulse for a capture request refused while a word was still streaming.
module prim_generic_flop_ser
   import prim_ser_pkg::*;
#(
   parameter int              Width      = 32,
   parameter int              ChunkW     = 8,
   parameter logic [Width-1:0] ResetValue = '0,
   parameter bit              MsbFirst   = 1'b0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [Width-1:0]  d_i,
   output logic [Width-1:0]  q_o,
   output logic              busy_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ChunkW-1:0] data_o,
   output logic              last_o,
   output logic              drop_o
);
   localparam int NumBeats = Width / ChunkW;
   localparam int CntW = NumBeats > 1 ? $clog2(NumBeats) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);
   if (Width % ChunkW != 0) begin : g_width_check
      $error("Width must be a multiple of ChunkW");
   end
   ser_state_e state;
   logic [CntW-1:0] cnt, idx;
   logic [NumBeats-1:0][ChunkW-1:0] chunks;
   logic send;
   assign send    = state == SEND;
   assign busy_o  = send;
   assign valid_o = send;
   assign last_o  = send && cnt == LastCnt;
   // MSB-first simply walks the chunk index downward from the top chunk
   assign idx     = MsbFirst ? LastCnt - cnt : cnt;
   assign chunks  = q_o;
   assign data_o  = chunks[idx];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         q_o    <= ResetValue;
         drop_o <= 1'b0;
      end else begin
         // a request is only taken in IDLE or on the edge that retires the final beat
         drop_o <= send && en_i && !(ready_i && last_o);
         if (!send) begin
            if (en_i) begin
               q_o   <= d_i;
               cnt   <= '0;
               state <= SEND;
            end
         end else if (ready_i) begin
            if (!last_o) cnt <= cnt + CntW'(1);
            else begin
               cnt <= '0;
               if (en_i) q_o <= d_i;
               else state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_prim_generic_flop_ser.sv
// tb_prim_generic_flop_ser: scoreboard bench for LSB-first and MSB-first serializers sharing one stimulus
module tb_prim_generic_flop_ser;
   localparam logic [31:0] RV = 32'hCAFE_F00D;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, ready = 1'b0;
   logic [31:0] d = '0;
   logic [31:0] q0, q1;
   logic [7:0] data0, data1;
   logic busy0, busy1, valid0, valid1, last0, last1, drop0, drop1;
   int vectors = 0, errs = 0;
   logic [8:0] sb0[$], sb1[$];
   always #5 clk = ~clk;
   prim_generic_flop_ser #(.Width(32), .ChunkW(8), .ResetValue(RV), .MsbFirst(1'b0)) u_lsb (
      .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .q_o(q0), .busy_o(busy0), .valid_o(valid0),
      .ready_i(ready), .data_o(data0), .last_o(last0), .drop_o(drop0));
   prim_generic_flop_ser #(.Width(32), .ChunkW(8), .ResetValue(RV), .MsbFirst(1'b1)) u_msb (
      .clk_i(clk), .rst_i(rst), .en_i(en), .d_i(d), .q_o(q1), .busy_o(busy1), .valid_o(valid1),
      .ready_i(ready), .data_o(data1), .last_o(last1), .drop_o(drop1));
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && valid0 && ready) begin
         vectors++;
         if (sb0.size() == 0) begin
            errs++;
            $display("FAIL lsb_beat unexpected beat got %h", {last0, data0});
         end else begin
            e = sb0.pop_front();
            if ({last0, data0} !== e) begin
               errs++;
               $display("FAIL lsb_beat got last=%b data=%h want last=%b data=%h", last0, data0, e[8], e[7:0]);
            end
         end
      end
      if (!rst && valid1 && ready) begin
         vectors++;
         if (sb1.size() == 0) begin
            errs++;
            $display("FAIL msb_beat unexpected beat got %h", {last1, data1});
         end else begin
            e = sb1.pop_front();
            if ({last1, data1} !== e) begin
               errs++;
               $display("FAIL msb_beat got last=%b data=%h want last=%b data=%h", last1, data1, e[8], e[7:0]);
            end
         end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         sb0.push_back({i == 3, w[8*i +: 8]});
         sb1.push_back({i == 3, w[8*(3-i) +: 8]});
      end
   endtask
   task automatic drain(output int cyc);
      cyc = 0;
      while ((sb0.size() != 0 || sb1.size() != 0) && cyc < 40) begin
         @(negedge clk);
         #1;
         cyc++;
      end
   endtask
   task automatic capture(input logic [31:0] w);
      en = 1'b1;
      d = w;
      push_word(w);
      tick();
      en = 1'b0;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if (q0 !== RV || q1 !== RV) begin
         errs++;
         $display("FAIL reset_q got %h/%h want %h", q0, q1, RV);
      end
      vectors++;
      if ({busy0, valid0, last0, drop0} !== 4'b0) begin
         errs++;
         $display("FAIL reset_flags got %b want 0000", {busy0, valid0, last0, drop0});
      end
      vectors++;
      if (data0 !== 8'h0D) begin
         errs++;
         $display("FAIL reset_data got %h want 0d", data0);
      end
      rst = 1'b0;
      ready = 1'b1;
      tick();
      vectors++;
      if (valid0 !== 1'b0 || q0 !== RV) begin
         errs++;
         $display("FAIL idle_hold got valid=%b q=%h want valid=0 q=%h", valid0, q0, RV);
      end
   endtask
   task automatic test_single;
      int cyc;
      ready = 1'b1;
      capture(32'h1122_3344);
      vectors++;
      if (busy0 !== 1'b1 || data0 !== 8'h44) begin
         errs++;
         $display("FAIL single_start got busy=%b data=%h want busy=1 data=44", busy0, data0);
      end
      drain(cyc);
      vectors++;
      if (cyc !== 4) begin
         errs++;
         $display("FAIL single_cycles got %0d want 4", cyc);
      end
      tick();
      vectors++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         errs++;
         $display("FAIL single_idle got busy=%b/%b want 0/0", busy0, busy1);
      end
   endtask
   task automatic test_backpressure;
      int cyc;
      ready = 1'b1;
      capture(32'h1122_3344);
      tick();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         vectors++;
         if (valid0 !== 1'b1 || data0 !== 8'h33 || last0 !== 1'b0 || q0 !== 32'h1122_3344) begin
            errs++;
            $display("FAIL bp_hold got valid=%b data=%h last=%b q=%h want 1 33 0 11223344", valid0, data0, last0, q0);
         end
         tick();
      end
      ready = 1'b1;
      drain(cyc);
      vectors++;
      if (sb0.size() !== 0) begin
         errs++;
         $display("FAIL bp_drain got %0d pending want 0", sb0.size());
      end
      tick();
   endtask
   task automatic test_back_to_back;
      int cyc;
      ready = 1'b1;
      capture(32'h1122_3344);
      tick();
      tick();
      tick();
      en = 1'b1;
      d = 32'hAABB_CCDD;
      push_word(32'hAABB_CCDD);
      tick();
      en = 1'b0;
      vectors++;
      if (valid0 !== 1'b1 || data0 !== 8'hDD || drop0 !== 1'b0 || q0 !== 32'hAABB_CCDD) begin
         errs++;
         $display("FAIL b2b_next got valid=%b data=%h drop=%b q=%h want 1 dd 0 aabbccdd", valid0, data0, drop0, q0);
      end
      drain(cyc);
      vectors++;
      if (cyc !== 4) begin
         errs++;
         $display("FAIL b2b_cycles got %0d want 4", cyc);
      end
      tick();
   endtask
   task automatic test_refused;
      int cyc;
      ready = 1'b1;
      capture(32'h1122_3344);
      en = 1'b1;
      d = 32'h5566_7788;
      tick();
      en = 1'b0;
      vectors++;
      if (drop0 !== 1'b1 || q0 !== 32'h1122_3344) begin
         errs++;
         $display("FAIL refuse_pulse got drop=%b q=%h want 1 11223344", drop0, q0);
      end
      tick();
      vectors++;
      if (drop0 !== 1'b0) begin
         errs++;
         $display("FAIL refuse_single got drop=%b want 0", drop0);
      end
      drain(cyc);
      vectors++;
      if (sb0.size() !== 0 || q0 !== 32'h1122_3344) begin
         errs++;
         $display("FAIL refuse_stream got pending=%0d q=%h want 0 11223344", sb0.size(), q0);
      end
      tick();
      vectors++;
      if (busy0 !== 1'b0) begin
         errs++;
         $display("FAIL refuse_idle got busy=%b want 0", busy0);
      end
   endtask
   task automatic test_reset_mid_and_msb;
      int cyc;
      ready = 1'b1;
      capture(32'h1122_3344);
      tick();
      tick();
      rst = 1'b1;
      en = 1'b1;
      tick();
      rst = 1'b0;
      en = 1'b0;
      sb0.delete();
      sb1.delete();
      vectors++;
      if (q0 !== RV || q1 !== RV || busy0 !== 1'b0 || valid1 !== 1'b0 || drop0 !== 1'b0) begin
         errs++;
         $display("FAIL mid_reset got q=%h/%h busy=%b valid=%b drop=%b want %h idle", q0, q1, busy0, valid1, drop0, RV);
      end
      capture(32'h1122_3344);
      vectors++;
      if (data1 !== 8'h11) begin
         errs++;
         $display("FAIL msb_first got %h want 11", data1);
      end
      drain(cyc);
      vectors++;
      if (sb1.size() !== 0) begin
         errs++;
         $display("FAIL msb_drain got %0d pending want 0", sb1.size());
      end
      tick();
   endtask
   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_refused();
      test_reset_mid_and_msb();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
